// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, functs,
// ALU control codes and the 4-bit FSM state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_MEMADR = 4'd2;
  localparam state_t S_MEMRD  = 4'd3;
  localparam state_t S_MEMWB  = 4'd4;
  localparam state_t S_MEMWR  = 4'd5;
  localparam state_t S_EXEC   = 4'd6;
  localparam state_t S_ALUWB  = 4'd7;
  localparam state_t S_BRANCH = 4'd8;
  localparam state_t S_ADDIEX = 4'd9;
  localparam state_t S_ADDIWB = 4'd10;
  localparam state_t S_JUMP   = 4'd11;

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU control decode: fixed add/sub for address and compare work, funct-driven
// for R-type execute. funct_valid flags the supported R-type subset.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       funct_valid_o
);

  logic [2:0] fn_ctrl;

  always_comb begin
    fn_ctrl       = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  fn_ctrl = ALU_ADD;
      FN_SUB:  fn_ctrl = ALU_SUB;
      FN_AND:  fn_ctrl = ALU_AND;
      FN_OR:   fn_ctrl = ALU_OR;
      FN_SLT:  fn_ctrl = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

  always_comb begin
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      default:   alucontrol_o = fn_ctrl;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: state register, next-state
// and Moore output decode, memory-ready stalls and the retired-instruction counter.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit HAS_MEM_READY = 1'b1,
  parameter int RETIRE_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                iord,
  output logic                memwrite,
  output logic                irwrite,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic [2:0]          alucontrol,
  output logic                pcen,
  output logic [3:0]          state_dbg,
  output logic                retire,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired_cnt
);

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] cnt_q, cnt_d;

  logic       ready;
  logic [1:0] aluop;
  logic [2:0] dec_ctrl;
  logic       funct_valid;
  logic       alu_used;
  logic       pcwrite, branch;
  logic       irwrite_r, memwrite_r, regwrite_r, retire_r, illegal_r;

  assign ready = HAS_MEM_READY ? mem_ready : 1'b1;

  mips_alu_decoder u_aludec (
    .aluop_i       (aluop),
    .funct_i       (funct),
    .alucontrol_o  (dec_ctrl),
    .funct_valid_o (funct_valid)
  );

  always_comb begin
    state_d    = S_FETCH;
    aluop      = ALUOP_ADD;
    alu_used   = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irwrite_r  = 1'b0;
    memwrite_r = 1'b0;
    regwrite_r = 1'b0;
    retire_r   = 1'b0;
    illegal_r  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_used = 1'b1;
        alusrcb  = 2'b01;
        if (ready) begin
          irwrite_r = 1'b1;
          pcwrite   = 1'b1;
          state_d   = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_used = 1'b1;
        alusrcb  = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            if (funct_valid) state_d = S_EXEC;
            else             illegal_r = 1'b1;
          end
          default: illegal_r = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_used = 1'b1;
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_r = 1'b1;
        retire_r   = 1'b1;
      end
      // The write strobe stays up for the whole stall; retire only on completion.
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_r = 1'b1;
        if (ready) retire_r = 1'b1;
        else       state_d  = S_MEMWR;
      end
      S_EXEC: begin
        alu_used = 1'b1;
        alusrca  = 1'b1;
        aluop    = ALUOP_FUNCT;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_r = 1'b1;
        retire_r   = 1'b1;
      end
      S_BRANCH: begin
        alu_used = 1'b1;
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = 2'b01;
        branch   = 1'b1;
        retire_r = 1'b1;
      end
      S_ADDIEX: begin
        alu_used = 1'b1;
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        state_d  = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_r = 1'b1;
        retire_r   = 1'b1;
      end
      S_JUMP: begin
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        retire_r = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked combinationally so an async reset kills them mid-cycle.
  assign irwrite    = irwrite_r  & ~reset;
  assign memwrite   = memwrite_r & ~reset;
  assign regwrite   = regwrite_r & ~reset;
  assign retire     = retire_r   & ~reset;
  assign illegal    = illegal_r  & ~reset;
  assign pcen       = (pcwrite | (branch & zero)) & ~reset;
  assign alucontrol = alu_used ? dec_ctrl : 3'b000;
  assign state_dbg  = state_q;
  assign retired_cnt = cnt_q;

  assign cnt_d = retire_r ? cnt_q + {{(RETIRE_W-1){1'b0}}, 1'b1} : cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle outputs; one process compares every cycle.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       pcen, retire, illegal;
  logic [3:0] state_dbg, retired_cnt;

  mips_multicycle_ctrl #(.HAS_MEM_READY(1'b1), .RETIRE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .pcen(pcen), .state_dbg(state_dbg), .retire(retire),
    .illegal(illegal), .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluc;
    logic pcen, retire, illegal;
    logic [3:0] cnt;
  } exp_t;

  typedef struct { exp_t v; string tag; } rec_t;
  typedef struct { logic [3:0] cnt; string name; } pin_t;

  rec_t rq[$];
  pin_t pq[$];
  int checks = 0, errors = 0;
  logic [3:0] model_cnt;

  // Compare process: wakes on every clock edge and on async reset assertion.
  always begin
    rec_t r;
    pin_t p;
    exp_t act;
    @(posedge clk or posedge reset);
    #2;
    act = {state_dbg, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, retire, illegal, retired_cnt};
    if (rq.size() > 0) begin
      r = rq.pop_front();
      checks++;
      if (act !== r.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", r.tag, act, r.v);
      end
    end
    while (pq.size() > 0) begin
      p = pq.pop_front();
      checks++;
      if (retired_cnt !== p.cnt) begin
        errors++;
        $display("FAIL %s: retired_cnt got %0d expected %0d", p.name, retired_cnt, p.cnt);
      end
    end
  end

  function automatic exp_t base(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic exp_t fetch_rec();
    exp_t e;
    e = base(S_FETCH);
    e.alusrcb = 2'b01;
    e.aluc = 3'b010;
    return e;
  endfunction

  function automatic bit r_legal(input logic [5:0] f);
    return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a;
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  task automatic push(input exp_t e, input string tag);
    rec_t r;
    e.cnt = model_cnt;
    r.v = e;
    r.tag = tag;
    rq.push_back(r);
    if (e.retire) model_cnt = model_cnt + 4'd1;
  endtask

  task automatic pin(input string name, input logic [3:0] c);
    pin_t p;
    p.name = name;
    p.cnt = c;
    pq.push_back(p);
  endtask

  // One cycle: inputs for this cycle, its expected outputs, then advance to next edge+1.
  task automatic step(input logic rdy, input exp_t e, input string tag);
    mem_ready = rdy;
    push(e, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fstall, input int mstall, input logic idle_rdy,
                           input bit abort, input string tag);
    exp_t e;
    bit legal;
    op = o; funct = f; zero = z;
    for (int i = 0; i < fstall; i++) step(1'b0, fetch_rec(), {tag, "_fetchwait"});
    e = fetch_rec(); e.irwrite = 1'b1; e.pcen = 1'b1;
    step(1'b1, e, {tag, "_fetch"});
    legal = (o == T_LW || o == T_SW || o == T_BEQ || o == T_ADDI || o == T_J ||
             (o == T_R && r_legal(f)));
    e = base(S_DECODE); e.alusrcb = 2'b11; e.aluc = 3'b010; e.illegal = !legal;
    step(idle_rdy, e, {tag, "_decode"});
    if (!legal) return;
    if (o == T_LW || o == T_SW) begin
      e = base(S_MEMADR); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluc = 3'b010;
      step(idle_rdy, e, {tag, "_memadr"});
      for (int i = 0; i < mstall; i++) begin
        e = base(o == T_LW ? S_MEMRD : S_MEMWR); e.iord = 1'b1; e.memwrite = (o == T_SW);
        if (abort) begin
          mem_ready = 1'b0;
          push(e, {tag, "_memwait"});
          #5;
          reset = 1'b1;
          model_cnt = 4'd0;
          push(fetch_rec(), {tag, "_async_reset"});
          @(posedge clk);
          #1;
          reset = 1'b0;
          return;
        end
        step(1'b0, e, {tag, "_memwait"});
      end
      e = base(o == T_LW ? S_MEMRD : S_MEMWR); e.iord = 1'b1;
      e.memwrite = (o == T_SW); e.retire = (o == T_SW);
      step(1'b1, e, {tag, "_memdone"});
      if (o == T_LW) begin
        e = base(S_MEMWB); e.memtoreg = 1'b1; e.regwrite = 1'b1; e.retire = 1'b1;
        step(idle_rdy, e, {tag, "_memwb"});
      end
    end else if (o == T_R) begin
      e = base(S_EXEC); e.alusrca = 1'b1; e.aluc = r_alu(f);
      step(idle_rdy, e, {tag, "_exec"});
      e = base(S_ALUWB); e.regdst = 1'b1; e.regwrite = 1'b1; e.retire = 1'b1;
      step(idle_rdy, e, {tag, "_aluwb"});
    end else if (o == T_BEQ) begin
      e = base(S_BRANCH); e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01;
      e.pcen = z; e.retire = 1'b1;
      step(idle_rdy, e, {tag, "_branch"});
    end else if (o == T_ADDI) begin
      e = base(S_ADDIEX); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluc = 3'b010;
      step(idle_rdy, e, {tag, "_addiex"});
      e = base(S_ADDIWB); e.regwrite = 1'b1; e.retire = 1'b1;
      step(idle_rdy, e, {tag, "_addiwb"});
    end else begin
      e = base(S_JUMP); e.pcsrc = 2'b10; e.pcen = 1'b1; e.retire = 1'b1;
      step(idle_rdy, e, {tag, "_jump"});
    end
  endtask

  initial begin
    reset = 1'b1; op = '0; funct = '0; zero = 1'b1; mem_ready = 1'b1; model_cnt = 4'd0;
    @(posedge clk);
    #1;
    push(fetch_rec(), "reset_hold");
    pin("reset_cnt", 4'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(T_R, 6'h20, 1'b0, 0, 0, 1'b1, 0, "add");
    pin("cnt_after_add", 4'd1);
    run_instr(T_LW, 6'h00, 1'b0, 0, 3, 1'b1, 0, "lw_stall3");
    run_instr(T_BEQ, 6'h00, 1'b1, 0, 0, 1'b1, 0, "beq_taken");
    run_instr(T_BEQ, 6'h00, 1'b0, 0, 0, 1'b0, 0, "beq_nottaken");
    pin("cnt_after_beq", 4'd4);
    run_instr(6'b111111, 6'h00, 1'b1, 0, 0, 1'b1, 0, "bad_op");
    pin("cnt_after_bad_op", 4'd4);
    run_instr(T_R, 6'h3f, 1'b1, 0, 0, 1'b1, 0, "bad_funct");
    pin("cnt_after_bad_funct", 4'd4);
    run_instr(T_SW, 6'h00, 1'b1, 0, 2, 1'b0, 0, "sw_stall2");
    run_instr(T_ADDI, 6'h00, 1'b1, 0, 0, 1'b0, 0, "addi");
    run_instr(T_R, 6'h22, 1'b1, 0, 0, 1'b0, 0, "sub");
    run_instr(T_R, 6'h24, 1'b0, 0, 0, 1'b1, 0, "and");
    run_instr(T_R, 6'h25, 1'b0, 0, 0, 1'b1, 0, "or");
    run_instr(T_R, 6'h2a, 1'b0, 0, 0, 1'b1, 0, "slt");
    run_instr(T_J, 6'h00, 1'b0, 2, 0, 1'b1, 0, "j_fetchstall");
    pin("cnt_before_abort", 4'd11);
    run_instr(T_SW, 6'h00, 1'b0, 0, 3, 1'b1, 1, "sw_abort");
    pin("cnt_after_abort", 4'd0);
    for (int i = 0; i < 16; i++) begin
      run_instr(T_J, 6'h00, 1'b0, 0, 0, 1'b1, 0, $sformatf("j%0d", i));
      if (i == 14) pin("cnt_j15", 4'd15);
    end
    pin("cnt_wrap", 4'd0);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
